// File: rtl/hazard_controller_if.sv
// Decode-side request and hazard-control response bundle between the pipeline
// datapath (master) and the hazard controller (slave).
interface hazard_controller_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] RA1D;
    logic [REG_W-1:0] RA2D;
    logic [REG_W-1:0] WA3D;
    logic             RegWriteD;
    logic             MemToRegD;
    logic             BranchTakenE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemToRegD, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemToRegD, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for a 5-stage ARM pipeline: shadows E/M/W
// register-write info to drive forwarding selects, stalls and flushes.
module hazard_controller #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  hz
);
    localparam logic [REG_W-1:0] PC_ADDR = REG_W'(PC_REG);

    typedef struct packed {
        logic [REG_W-1:0] ra1;
        logic [REG_W-1:0] ra2;
        logic [REG_W-1:0] wa3;
        logic             reg_write;
        logic             mem_to_reg;
        logic             pc_wr;
    } ex_stage_t;

    typedef struct packed {
        logic [REG_W-1:0] wa3;
        logic             reg_write;
        logic             pc_wr;
    } wb_stage_t;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_RESULTW = 2'b01,
        FWD_ALUM    = 2'b10
    } fwd_sel_t;

    ex_stage_t        e_q;
    wb_stage_t        m_q;
    wb_stage_t        w_q;
    logic [CNT_W-1:0] count_q;

    logic pc_wr_d;
    logic ldr_stall;
    logic pc_wr_pend;
    logic stall_f;
    logic flush_d;
    logic flush_e;

    // R15 reads the PC value held in the pipe, so it is never forwarded.
    function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] src,
                                         input wb_stage_t m, input wb_stage_t w);
        if (src == PC_ADDR)                    return FWD_REGFILE;
        else if (m.reg_write && m.wa3 == src)  return FWD_ALUM;
        else if (w.reg_write && w.wa3 == src)  return FWD_RESULTW;
        else                                   return FWD_REGFILE;
    endfunction

    always_comb begin
        pc_wr_d    = hz.RegWriteD && (hz.WA3D == PC_ADDR);
        ldr_stall  = e_q.mem_to_reg && e_q.reg_write &&
                     ((e_q.wa3 == hz.RA1D) || (e_q.wa3 == hz.RA2D));
        pc_wr_pend = pc_wr_d || e_q.pc_wr || m_q.pc_wr;
        stall_f    = ldr_stall || pc_wr_pend;
        flush_d    = pc_wr_pend || w_q.pc_wr || hz.BranchTakenE;
        flush_e    = ldr_stall || hz.BranchTakenE;
    end

    // NOTE: outputs are gated by reset combinationally so they read 0 during the
    // reset cycle itself, not only after the clearing edge.
    always_comb begin
        hz.ForwardAE  = reset ? FWD_REGFILE : fwd_sel(e_q.ra1, m_q, w_q);
        hz.ForwardBE  = reset ? FWD_REGFILE : fwd_sel(e_q.ra2, m_q, w_q);
        hz.StallF     = stall_f   && !reset;
        hz.StallD     = ldr_stall && !reset;
        hz.FlushD     = flush_d   && !reset;
        hz.FlushE     = flush_e   && !reset;
        hz.StallCount = reset ? '0 : count_q;
    end

    // NOTE: all state uses non-blocking assignments so every stage samples the
    // pre-edge value of the stage in front of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            count_q <= '0;
        end else begin
            if (flush_e) begin
                e_q <= '0;
            end else begin
                e_q <= '{ra1: hz.RA1D, ra2: hz.RA2D, wa3: hz.WA3D,
                         reg_write: hz.RegWriteD, mem_to_reg: hz.MemToRegD,
                         pc_wr: pc_wr_d};
            end
            m_q <= '{wa3: e_q.wa3, reg_write: e_q.reg_write, pc_wr: e_q.pc_wr};
            w_q <= m_q;
            if (stall_f && count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end
endmodule
